// File: rtl/hilo_muldiv_ctrl_pkg.sv
// hilo_muldiv_ctrl_pkg
// Shared definitions for the HI/LO multiply/divide unit: the opcode encoding
// driven by decode, the sequencer state encoding and the divide-by-zero LO value.
// Configuration macro: MULDIV_SIGNED_EN (adds the SIGN state used by MULT/DIV).
package hilo_muldiv_ctrl_pkg;

  localparam int MULDIV_WIDTH = 32;

  // LO value written by a divide whose divisor is zero.
  localparam logic [MULDIV_WIDTH-1:0] DIV0_LO = '1;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
`ifdef MULDIV_SIGNED_EN
    ,
    ST_SIGN = 2'd3
`endif
  } hilo_state_t;

endpackage

// File: rtl/hilo_muldiv_ctrl_datapath.sv
// muldiv_datapath
// Iterative arithmetic for the HI/LO unit: a shift-add multiplier and a
// restoring divider sharing one accumulator/low-half register pair, plus the
// final sign correction used by the signed ops.
// Configuration macro: MULDIV_SIGNED_EN (magnitude capture and sign fix-up).
// Ports:
//   clk, rst         core clock, asynchronous active-high reset
//   i_load           capture operands for a new multiply/divide
//   i_loadDiv        the captured op is a divide
//   i_loadDz         the captured op is a divide by zero
//   i_loadSigned     operands are two's complement (MULDIV_SIGNED_EN only)
//   i_a, i_b         rs / rt operands
//   i_step           perform one iteration this cycle
//   o_stepHi/Lo      HI/LO as they will be after this cycle's iteration
//   o_curHi/Lo       HI/LO as currently held
//   o_fixHi/Lo       sign-corrected HI/LO (MULDIV_SIGNED_EN only)
module muldiv_datapath
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_loadDiv,
  input  logic             i_loadDz,
`ifdef MULDIV_SIGNED_EN
  input  logic             i_loadSigned,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_stepHi,
  output logic [WIDTH-1:0] o_stepLo,
  output logic [WIDTH-1:0] o_curHi,
`ifdef MULDIV_SIGNED_EN
  output logic [WIDTH-1:0] o_fixHi,
  output logic [WIDTH-1:0] o_fixLo,
`endif
  output logic [WIDTH-1:0] o_curLo
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_low;
  logic [WIDTH-1:0] r_opb;
  logic             r_isDiv;

  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_divShift;
  logic [WIDTH:0]   w_divDiff;
  logic [WIDTH-1:0] w_accNext;
  logic [WIDTH-1:0] w_lowNext;

`ifdef MULDIV_SIGNED_EN
  logic             r_negRes;
  logic             r_negRem;
  logic             w_signA;
  logic             w_signB;
  logic [2*WIDTH-1:0] w_prodNeg;

  // Signed ops iterate on magnitudes; the signs are kept for the SIGN step.
  assign w_signA = i_loadSigned & i_a[WIDTH-1];
  assign w_signB = i_loadSigned & i_b[WIDTH-1];
  assign w_absA  = w_signA ? -i_a : i_a;
  assign w_absB  = w_signB ? -i_b : i_b;
`else
  assign w_absA  = i_a;
  assign w_absB  = i_b;
`endif

  // One iteration. Multiply: add the multiplicand when the multiplier LSB is
  // set, then shift the 2*WIDTH product right. Divide: shift the next dividend
  // bit into the remainder and keep the difference only if it did not borrow.
  // The remainder always stays below the divisor, so WIDTH bits hold it.
  always_comb begin
    w_mulSum   = {1'b0, r_acc} + (r_low[0] ? {1'b0, r_opb} : '0);
    w_divShift = {r_acc, r_low[WIDTH-1]};
    w_divDiff  = w_divShift - {1'b0, r_opb};
    w_accNext  = w_mulSum[WIDTH:1];
    w_lowNext  = {w_mulSum[0], r_low[WIDTH-1:1]};
    if (r_isDiv) begin
      if (w_divDiff[WIDTH]) begin
        w_accNext = w_divShift[WIDTH-1:0];
        w_lowNext = {r_low[WIDTH-2:0], 1'b0};
      end else begin
        w_accNext = w_divDiff[WIDTH-1:0];
        w_lowNext = {r_low[WIDTH-2:0], 1'b1};
      end
    end
  end

  // Operand capture and iteration. A divide by zero preloads the final
  // HI/LO values directly so the controller can write them after one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_low   <= '0;
      r_opb   <= '0;
      r_isDiv <= 1'b0;
    end else if (i_load) begin
      r_isDiv <= i_loadDiv;
      if (i_loadDz) begin
        r_acc <= i_a;
        r_low <= WIDTH'(DIV0_LO);
        r_opb <= '0;
      end else if (i_loadDiv) begin
        r_acc <= '0;
        r_low <= w_absA;
        r_opb <= w_absB;
      end else begin
        r_acc <= '0;
        r_low <= w_absB;
        r_opb <= w_absA;
      end
    end else if (i_step) begin
      r_acc <= w_accNext;
      r_low <= w_lowNext;
    end
  end

`ifdef MULDIV_SIGNED_EN
  // Sign flags for the fix-up step: the product/quotient is negated when the
  // operand signs differ, and the remainder follows the dividend's sign.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
    end else if (i_load) begin
      r_negRes <= w_signA ^ w_signB;
      r_negRem <= w_signA;
    end
  end

  // Sign correction applied in the SIGN state.
  always_comb begin
    w_prodNeg = -{r_acc, r_low};
    if (r_isDiv) begin
      o_fixHi = r_negRem ? -r_acc : r_acc;
      o_fixLo = r_negRes ? -r_low : r_low;
    end else begin
      o_fixHi = r_negRes ? w_prodNeg[2*WIDTH-1:WIDTH] : r_acc;
      o_fixLo = r_negRes ? w_prodNeg[WIDTH-1:0] : r_low;
    end
  end
`endif

  assign o_stepHi = w_accNext;
  assign o_stepLo = w_lowNext;
  assign o_curHi  = r_acc;
  assign o_curLo  = r_low;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair. Runs
// MULT/MULTU/DIV/DIVU over WIDTH iterations, executes MTHI/MTLO immediately,
// feeds HI or LO to the pipeline for MFHI/MFLO and stalls the front of the
// pipeline while busy and an instruction needs the unit.
// Configuration macro: MULDIV_SIGNED_EN (signed MULT/DIV with a SIGN state;
// when undefined MULT/DIV behave exactly like MULTU/DIVU).
// Ports:
//   clk, rst      core clock, asynchronous active-high reset
//   start_ex      unit instruction valid in EX
//   op_ex         muldiv_op_t opcode
//   src_a_ex      rs operand (multiplicand/dividend/MTxx data)
//   src_b_ex      rt operand (multiplier/divisor)
//   mfhi_ex       MFHI in EX
//   mflo_ex       MFLO in EX
//   hi_lo_ex      HI if mfhi_ex else LO (combinational)
//   stall         freeze IF/ID/EX while busy and the unit is needed
//   busy          an operation is in flight
//   div_by_zero   high for the single busy cycle of a divide by zero
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_ex,
  input  logic [2:0]       op_ex,
  input  logic [WIDTH-1:0] src_a_ex,
  input  logic [WIDTH-1:0] src_b_ex,
  input  logic             mfhi_ex,
  input  logic             mflo_ex,
  output logic [WIDTH-1:0] hi_lo_ex,
  output logic             stall,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  hilo_state_t      r_state;
  hilo_state_t      w_stateNext;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countNext;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] w_hiNext;
  logic [WIDTH-1:0] w_loNext;
  logic             r_dz;

  muldiv_op_t       w_op;
  logic             w_isMul;
  logic             w_isDiv;
  logic             w_divZero;
  logic             w_load;
  logic             w_step;

  logic [WIDTH-1:0] w_stepHi;
  logic [WIDTH-1:0] w_stepLo;
  logic [WIDTH-1:0] w_curHi;
  logic [WIDTH-1:0] w_curLo;

`ifdef MULDIV_SIGNED_EN
  logic             r_signed;
  logic             w_opSigned;
  logic [WIDTH-1:0] w_fixHi;
  logic [WIDTH-1:0] w_fixLo;

  assign w_opSigned = (w_op == OP_MULT) || (w_op == OP_DIV);
`endif

  assign w_op      = muldiv_op_t'(op_ex);
  assign w_isMul   = (w_op == OP_MULT) || (w_op == OP_MULTU);
  assign w_isDiv   = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_divZero = w_isDiv && (src_b_ex == '0);
  assign w_load    = (r_state == ST_IDLE) && start_ex && (w_isMul || w_isDiv);

  muldiv_datapath #(
    .WIDTH        (WIDTH)
  ) u_datapath (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_loadDiv    (w_isDiv),
    .i_loadDz     (w_divZero),
`ifdef MULDIV_SIGNED_EN
    .i_loadSigned (w_opSigned),
    .o_fixHi      (w_fixHi),
    .o_fixLo      (w_fixLo),
`endif
    .i_a          (src_a_ex),
    .i_b          (src_b_ex),
    .i_step       (w_step),
    .o_stepHi     (w_stepHi),
    .o_stepLo     (w_stepLo),
    .o_curHi      (w_curHi),
    .o_curLo      (w_curLo)
  );

  // Sequencer. New work is only accepted in IDLE; a start arriving while
  // busy is stalled and re-presented by the pipeline. The last iteration's
  // result is written in the same edge that leaves MUL/DIV, so unsigned ops
  // complete WIDTH edges after acceptance.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_hiNext    = r_hi;
    w_loNext    = r_lo;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_ex) begin
          if (w_op == OP_MTHI) begin
            w_hiNext = src_a_ex;
          end else if (w_op == OP_MTLO) begin
            w_loNext = src_a_ex;
          end else if (w_isMul) begin
            w_stateNext = ST_MUL;
            w_countNext = CNT_W'(WIDTH - 1);
          end else if (w_isDiv) begin
            w_stateNext = ST_DIV;
            w_countNext = w_divZero ? '0 : CNT_W'(WIDTH - 1);
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if ((r_state == ST_DIV) && r_dz) begin
          w_hiNext    = w_curHi;
          w_loNext    = w_curLo;
          w_stateNext = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_count == '0) begin
            w_stateNext = ST_IDLE;
            w_hiNext    = w_stepHi;
            w_loNext    = w_stepLo;
`ifdef MULDIV_SIGNED_EN
            if (r_signed) begin
              w_stateNext = ST_SIGN;
              w_hiNext    = r_hi;
              w_loNext    = r_lo;
            end
`endif
          end else begin
            w_countNext = r_count - CNT_W'(1);
          end
        end
      end
`ifdef MULDIV_SIGNED_EN
      ST_SIGN: begin
        w_hiNext    = w_fixHi;
        w_loNext    = w_fixLo;
        w_stateNext = ST_IDLE;
      end
`endif
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // State, counter and architectural HI/LO. Reset abandons any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
      r_hi    <= w_hiNext;
      r_lo    <= w_loNext;
      if (w_load) begin
        r_dz <= w_divZero;
      end
    end
  end

`ifdef MULDIV_SIGNED_EN
  // Remembers whether the op in flight needs the SIGN step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_signed <= 1'b0;
    end else if (w_load) begin
      r_signed <= w_opSigned;
    end
  end
`endif

  // A decode-error start together with MFxx still reads the current HI/LO.
  assign busy        = (r_state != ST_IDLE);
  assign stall       = busy & (start_ex | mfhi_ex | mflo_ex);
  assign div_by_zero = (r_state == ST_DIV) & r_dz;
  assign hi_lo_ex    = mfhi_ex ? r_hi : r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl
// Self-checking bench for hilo_muldiv_ctrl. Operations are issued through a
// pipeline-like driver that honours stall; every MFHI/MFLO pushes the value the
// reference model predicts, and a monitor compares it when the read is accepted.
// Follows MULDIV_SIGNED_EN the same way the design does.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start_ex;
  logic [2:0]   op_ex;
  logic [W-1:0] src_a_ex;
  logic [W-1:0] src_b_ex;
  logic         mfhi_ex;
  logic         mflo_ex;
  logic [W-1:0] hi_lo_ex;
  logic         stall;
  logic         busy;
  logic         div_by_zero;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] expQ[$];
  logic [W-1:0] mHi = '0;
  logic [W-1:0] mLo = '0;
  logic [W-1:0] monExp;

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_ex    (start_ex),
    .op_ex       (op_ex),
    .src_a_ex    (src_a_ex),
    .src_b_ex    (src_b_ex),
    .mfhi_ex     (mfhi_ex),
    .mflo_ex     (mflo_ex),
    .hi_lo_ex    (hi_lo_ex),
    .stall       (stall),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic recordFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=no event required=event", name);
  endtask

  // Architectural reference: HI/LO after an instruction, its busy length in
  // cycles and the number of div_by_zero pulses, from plain integer arithmetic.
  function automatic void refModel(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] curHi, input logic [W-1:0] curLo,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo,
                                   output int lat, output int dz);
    logic [2*W-1:0] p;
    longint sa, sb, q, r;
    bit sgn;
    hi  = curHi;
    lo  = curLo;
    lat = 0;
    dz  = 0;
    sgn = SIGNED_EN && ((op == OP_MULT) || (op == OP_DIV));
    case (op)
      OP_MTHI: hi = a;
      OP_MTLO: lo = a;
      OP_MULT, OP_MULTU: begin
        if (sgn) p = longint'($signed(a)) * longint'($signed(b));
        else     p = {32'b0, a} * {32'b0, b};
        hi  = p[2*W-1:W];
        lo  = p[W-1:0];
        lat = sgn ? W + 1 : W;
      end
      OP_DIV, OP_DIVU: begin
        if (b == '0) begin
          hi  = a;
          lo  = '1;
          lat = 1;
          dz  = 1;
        end else if (sgn) begin
          sa  = longint'($signed(a));
          sb  = longint'($signed(b));
          q   = sa / sb;
          r   = sa % sb;
          lo  = q[W-1:0];
          hi  = r[W-1:0];
          lat = W + 1;
        end else begin
          lo  = a / b;
          hi  = a % b;
          lat = W;
        end
      end
      default: ;
    endcase
  endfunction

  // Issues one unit instruction, holding it while stalled. Optionally counts
  // the busy cycles and div_by_zero pulses that follow acceptance.
  task automatic applyStimulus(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit measure, input string tag, output int held);
    logic [W-1:0] eHi, eLo;
    int eLat, eDz, cyc, dzc;
    refModel(op, a, b, mHi, mLo, eHi, eLo, eLat, eDz);
    mHi = eHi;
    mLo = eLo;
    @(negedge clk);
    start_ex = 1'b1;
    op_ex    = op;
    src_a_ex = a;
    src_b_ex = b;
    #1;
    held = 0;
    while (stall && held < 200) begin
      @(negedge clk);
      #1;
      held++;
    end
    if (held >= 200) recordFail({tag, " stall release"});
    @(posedge clk);
    @(negedge clk);
    start_ex = 1'b0;
    op_ex    = OP_NOP;
    src_a_ex = $urandom;
    src_b_ex = $urandom;
    if (measure) begin
      cyc = 0;
      dzc = 0;
      #1;
      while (busy && cyc < 200) begin
        cyc++;
        if (div_by_zero) dzc++;
        @(negedge clk);
        #1;
      end
      checkOutput({tag, " busy cycles"}, cyc, eLat);
      checkOutput({tag, " div_by_zero pulses"}, dzc, eDz);
    end
  endtask

  // Issues MFHI/MFLO; the expected value goes to the scoreboard queue.
  task automatic readReg(input bit hi, output int held);
    expQ.push_back(hi ? mHi : mLo);
    @(negedge clk);
    mfhi_ex = hi;
    mflo_ex = !hi;
    #1;
    held = 0;
    while (stall && held < 200) begin
      @(negedge clk);
      #1;
      held++;
    end
    if (held >= 200) recordFail("read stall release");
    @(posedge clk);
    @(negedge clk);
    mfhi_ex = 1'b0;
    mflo_ex = 1'b0;
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return W'($urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard monitor: a read is accepted in a cycle with MFxx and no stall.
  always @(negedge clk) begin
    #2;
    if ((mfhi_ex || mflo_ex) && !stall) begin
      if (expQ.size() == 0) begin
        recordFail("unexpected read");
      end else begin
        monExp = expQ.pop_front();
        checkOutput(mfhi_ex ? "MFHI" : "MFLO", hi_lo_ex, monExp);
      end
    end
  end

  initial begin
    int held;
    muldiv_op_t rop;
    rst      = 1'b1;
    start_ex = 1'b0;
    op_ex    = OP_NOP;
    src_a_ex = '0;
    src_b_ex = '0;
    mfhi_ex  = 1'b0;
    mflo_ex  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset stall", stall, 0);
    checkOutput("reset div_by_zero", div_by_zero, 0);
    checkOutput("reset hi_lo_ex", hi_lo_ex, 0);
    @(negedge clk);
    rst = 1'b0;
    readReg(1'b1, held);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, "MULTU", held);
    readReg(1'b0, held);
    readReg(1'b1, held);

    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, "MULT", held);
    readReg(1'b1, held);
    readReg(1'b0, held);

    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, "DIV", held);
    readReg(1'b0, held);
    readReg(1'b1, held);

    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "DIV overflow", held);
    readReg(1'b0, held);
    readReg(1'b1, held);

    applyStimulus(OP_DIVU, 32'd5, 32'd0, 1'b1, "DIVU by zero", held);
    readReg(1'b1, held);
    readReg(1'b0, held);

    applyStimulus(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "MULTU held read", held);
    readReg(1'b0, held);
    checkOutput("MFLO stalled cycles", held, W - 1);

    applyStimulus(OP_MULTU, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0, "MULTU first", held);
    applyStimulus(OP_DIVU, 32'hFFFF_0000, 32'h0000_0007, 1'b1, "DIVU back-to-back", held);
    checkOutput("back-to-back start held", held, W - 1);
    readReg(1'b0, held);
    readReg(1'b1, held);

    applyStimulus(OP_MTHI, 32'h0000_1234, 32'h0, 1'b1, "MTHI", held);
    readReg(1'b1, held);
    applyStimulus(OP_MTLO, 32'hCAFE_F00D, 32'h0, 1'b0, "MTLO", held);
    readReg(1'b0, held);

    for (int i = 0; i < 30; i++) begin
      rop = muldiv_op_t'(3'($urandom_range(1, 6)));
      applyStimulus(rop, pickOperand(), pickOperand(), 1'b1, "random", held);
      readReg(1'b0, held);
      readReg(1'b1, held);
    end

    applyStimulus(OP_DIVU, 32'd1000, 32'd7, 1'b0, "DIVU pre-reset", held);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("busy after mid-op reset", busy, 0);
    checkOutput("hi_lo_ex after mid-op reset", hi_lo_ex, 0);
    mHi = '0;
    mLo = '0;
    readReg(1'b1, held);
    @(negedge clk);
    rst = 1'b0;
    readReg(1'b0, held);
    readReg(1'b1, held);

    repeat (3) @(negedge clk);
    if (expQ.size() != 0) recordFail("reads never accepted");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for one core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and runs shift-add multiply or restoring divide over WIDTH cycles. It supplies the HI or LO value that the pipeline carries to write-back for MFHI/MFLO. It stalls the pipeline while an operation is in flight and an instruction needs the unit.

## Interface
- WIDTH, 32, operand and HI/LO width
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- start_ex  in  1  valid unit instruction in EX
- op_ex  in  3  opcode from shared package: MULT, MULTU, DIV, DIVU, MTHI, MTLO
- src_a_ex  in  WIDTH  rs operand (multiplicand/dividend/MTxx data)
- src_b_ex  in  WIDTH  rt operand (multiplier/divisor)
- mfhi_ex  in  1  MFHI in EX
- mflo_ex  in  1  MFLO in EX
- hi_lo_ex  out  WIDTH  HI if mfhi_ex, else LO; combinational; pipelined toward write-back as the HI/LO result
- stall  out  1  freeze IF/ID/EX, bubble into MEM
- busy  out  1  state != IDLE
- div_by_zero  out  1  one-cycle pulse when a divide with src_b_ex==0 completes

## Operation
- States: IDLE, MUL, DIV, SIGN.
- IDLE, start_ex, MTHI/MTLO: HI or LO = src_a_ex at the next edge; stays in IDLE.
- IDLE, start_ex, multiply: latch operand magnitudes (signed ops only) and sign flag; clear accumulator; count = WIDTH-1; go to MUL.
- MUL: one shift-add step per cycle, 2*WIDTH-bit product.
- IDLE, start_ex, divide: latch magnitudes; go to DIV.
- DIV: one restoring step per cycle (remainder WIDTH+1 bits).
- MUL/DIV when count==0:
  - unsigned: write HI/LO, go to IDLE.
  - signed: go to SIGN.
- SIGN:
  - MULT: negate the 2*WIDTH product if operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Write HI/LO, go to IDLE.
- Results: multiply gives HI=product[2W-1:W], LO=product[W-1:0]. Divide gives LO=quotient, HI=remainder.
- Divide by zero: skip iteration, HI=src_a_ex, LO=all ones, pulse div_by_zero, return to IDLE after 1 cycle.
- Arithmetic is modulo 2^WIDTH per half. Signed -2^(W-1)/-1 yields LO=0x80000000, HI=0.
- stall = busy & (start_ex | mfhi_ex | mflo_ex).
- The stalled instruction is held by the pipeline and accepted on the first IDLE cycle.
- Unrelated instructions pass freely during busy.
- start_ex with mfhi_ex/mflo_ex in the same cycle is a decode error. The unit serves the read from the current HI/LO and accepts the start.

## Timing
- Reset values: HI=0, LO=0, state=IDLE, count=0, stall=0, busy=0, div_by_zero=0, hi_lo_ex=0.
- Start accepted at edge E. busy is high from E.
- Unsigned multiply/divide: HI/LO written at edge E+WIDTH. busy falls at the same edge. An MFxx held in EX reads the result in the cycle after that edge.
- Signed multiply/divide: latency is WIDTH+1 edges.
- MTHI/MTLO: readable in the next cycle.
- Reset mid-operation: immediately return to IDLE. HI/LO=0. The partial result is discarded.

## Configuration
- MULDIV_SIGNED_EN defined: MULT/DIV are signed as above, with the SIGN state present.
- MULDIV_SIGNED_EN undefined: MULT/DIV execute exactly as MULTU/DIVU, with no SIGN state and latency WIDTH for all ops. The divide-overflow rule does not apply.

## Structure
- Shared package holds:
  - muldiv_op_t enum, including a NOP encoding
  - hilo_state_t enum
  - DIV0_LO constant (all ones)
- One sub-module, muldiv_datapath: shift registers, adder/subtractor, negation.
- This block keeps the FSM, counter, HI/LO and stall logic.

## Test plan
- MULTU 0xFFFFFFFF × 0x00000002 -> after 32 cycles HI=0x00000001, LO=0xFFFFFFFE; busy high exactly 32 cycles.
- MULT 0xFFFFFFFD × 0x00000005 (macro on) -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1. With the macro off -> HI=0x00000004, LO=0xFFFFFFF1 after 32 cycles.
- DIV 0xFFFFFFF9 / 0x00000002 (macro on) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 5 / 0 -> HI=0x00000005, LO=0xFFFFFFFF, div_by_zero pulses once, busy for 1 cycle.
- MULTU, then MFLO held in EX -> stall high every cycle until done, then hi_lo_ex=new LO. A back-to-back start is held the same way.
- MTHI 0x00001234, MFHI next cycle -> hi_lo_ex=0x00001234. Assert rst at cycle 10 of a DIVU -> busy=0, HI=LO=0 immediately.
